// File: rtl/hazard_ctrl_pkg.sv
// Shared CPU definitions: instruction field positions, the HALT opcode and
// the hazard controller state encoding.
package cpu_pkg;

  localparam int OP_MSB = 15;
  localparam int OP_LSB = 12;
  localparam int RD_MSB = 11;
  localparam int RD_LSB = 8;
  localparam int RS_MSB = 7;
  localparam int RS_LSB = 4;
  localparam int RT_MSB = 3;
  localparam int RT_LSB = 0;

  localparam logic [3:0] HALT_OP = 4'hF;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    DRAIN    = 2'd2,
    HALTED   = 2'd3
  } hctl_state_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Interface bundling the decode-side inputs and pipeline-control outputs of
// hazard_ctrl. With HAZ_PERF_EN defined it also carries the two perf counters.
interface hazard_ctrl_if #(
  parameter int INST_W = 16,
  parameter int REG_W  = 4
);

  logic [INST_W-1:0] ifid_inst;
  logic              idex_memread;
  logic [REG_W-1:0]  idex_rd;
  logic              br_taken_ex;
  logic              imem_stall;
  logic              dmem_stall;
  logic              pc_write;
  logic              ifid_stall;
  logic              ifid_flush;
  logic              idex_flush;
  logic              be_freeze;
  logic              halted;
`ifdef HAZ_PERF_EN
  logic [15:0]       stall_cnt;
  logic [15:0]       flush_cnt;

  modport master (
    output ifid_inst, idex_memread, idex_rd, br_taken_ex, imem_stall, dmem_stall,
    input  pc_write, ifid_stall, ifid_flush, idex_flush, be_freeze, halted,
    input  stall_cnt, flush_cnt
  );

  modport slave (
    input  ifid_inst, idex_memread, idex_rd, br_taken_ex, imem_stall, dmem_stall,
    output pc_write, ifid_stall, ifid_flush, idex_flush, be_freeze, halted,
    output stall_cnt, flush_cnt
  );
`else
  modport master (
    output ifid_inst, idex_memread, idex_rd, br_taken_ex, imem_stall, dmem_stall,
    input  pc_write, ifid_stall, ifid_flush, idex_flush, be_freeze, halted
  );

  modport slave (
    input  ifid_inst, idex_memread, idex_rd, br_taken_ex, imem_stall, dmem_stall,
    output pc_write, ifid_stall, ifid_flush, idex_flush, be_freeze, halted
  );
`endif

endinterface

// File: rtl/hazard_ctrl_load_use.sv
// Load-use hazard detector: flags when the load in ID/EX writes a register
// that the instruction in IF/ID reads. r0 is hardwired zero, so it never
// creates a dependency.
module load_use_detect #(
  parameter int REG_W = 4
) (
  input  logic [REG_W-1:0] i_rs,
  input  logic [REG_W-1:0] i_rt,
  input  logic             i_memread,
  input  logic [REG_W-1:0] i_rd,
  output logic             o_hazard
);

  logic w_rd_nonzero;
  logic w_match;

  assign w_rd_nonzero = (i_rd != '0);
  assign w_match      = (i_rd == i_rs) || (i_rd == i_rt);
  assign o_hazard     = i_memread && w_rd_nonzero && w_match;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 16-bit five-stage core.
// Drives stall/flush for IF/ID and ID/EX, the PC write enable and the
// back-end freeze from load-use, taken-branch, memory-wait and HALT sources.
// Optional feature macro: HAZ_PERF_EN (adds saturating stall/flush counters).
module hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int         INST_W    = 16,
  parameter int         REG_W     = 4,
  parameter logic [3:0] HALT_OP   = cpu_pkg::HALT_OP,
  parameter int         DRAIN_CYC = 3
) (
  input  logic          clk,
  input  logic          rst,
  hazard_ctrl_if.slave  hif
);

  localparam int CNT_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  hctl_state_t       r_state;
  hctl_state_t       w_next;
  logic [CNT_W-1:0]  r_drain_cnt;
  logic [CNT_W-1:0]  w_drain_nxt;

  logic w_load_use;
  logic w_is_halt;
  logic w_run_rules;
  logic w_br_flush;
  logic w_pc_write;
  logic w_ifid_stall;
  logic w_ifid_flush;
  logic w_idex_flush;
  logic w_be_freeze;
  logic w_halted;
  logic w_unused_rd;

  // rd of the IF/ID instruction plays no part in hazard detection
  assign w_unused_rd = ^hif.ifid_inst[RD_MSB:RD_LSB];

  assign w_is_halt = (hif.ifid_inst[OP_MSB:OP_LSB] == HALT_OP);

  load_use_detect #(
    .REG_W (REG_W)
  ) u_lud (
    .i_rs      (hif.ifid_inst[RS_LSB +: REG_W]),
    .i_rt      (hif.ifid_inst[RT_LSB +: REG_W]),
    .i_memread (hif.idex_memread),
    .i_rd      (hif.idex_rd),
    .o_hazard  (w_load_use)
  );

  // State and drain counter; reset returns immediately to an empty RUN state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= RUN;
      r_drain_cnt <= '0;
    end else begin
      r_state     <= w_next;
      r_drain_cnt <= w_drain_nxt;
    end
  end

  // Next-state and control outputs; MEM_WAIT release reuses the RUN rules
  // in the same cycle, and rst overrides everything combinationally
  always_comb begin
    w_next       = r_state;
    w_drain_nxt  = r_drain_cnt;
    w_run_rules  = 1'b0;
    w_br_flush   = 1'b0;
    w_pc_write   = 1'b0;
    w_ifid_stall = 1'b0;
    w_ifid_flush = 1'b0;
    w_idex_flush = 1'b0;
    w_be_freeze  = 1'b0;
    w_halted     = 1'b0;

    case (r_state)
      RUN: begin
        w_run_rules = 1'b1;
      end
      MEM_WAIT: begin
        if (hif.dmem_stall) begin
          w_be_freeze  = 1'b1;
          w_ifid_stall = 1'b1;
        end else begin
          w_next      = RUN;
          w_run_rules = 1'b1;
        end
      end
      DRAIN: begin
        w_ifid_flush = 1'b1;
        if (hif.dmem_stall) begin
          w_be_freeze = 1'b1;
        end else if (hif.br_taken_ex) begin
          // HALT was fetched down a mispredicted path: resume execution
          w_idex_flush = 1'b1;
          w_pc_write   = 1'b1;
          w_br_flush   = 1'b1;
          w_drain_nxt  = '0;
          w_next       = RUN;
        end else if (r_drain_cnt == CNT_W'(DRAIN_CYC - 1)) begin
          w_next = HALTED;
        end else begin
          w_drain_nxt = r_drain_cnt + CNT_W'(1);
        end
      end
      HALTED: begin
        w_halted     = 1'b1;
        w_ifid_flush = 1'b1;
        w_idex_flush = 1'b1;
      end
      default: begin
        w_next = RUN;
      end
    endcase

    if (w_run_rules) begin
      if (hif.dmem_stall) begin
        w_next       = MEM_WAIT;
        w_be_freeze  = 1'b1;
        w_ifid_stall = 1'b1;
      end else if (hif.br_taken_ex) begin
        w_ifid_flush = 1'b1;
        w_idex_flush = 1'b1;
        w_pc_write   = 1'b1;
        w_br_flush   = 1'b1;
      end else if (w_load_use) begin
        // one bubble suffices: the load leaves ID/EX next cycle
        w_ifid_stall = 1'b1;
        w_idex_flush = 1'b1;
      end else if (hif.imem_stall) begin
        w_ifid_flush = 1'b1;
      end else if (w_is_halt) begin
        w_ifid_flush = 1'b1;
        w_next       = DRAIN;
        w_drain_nxt  = '0;
      end else begin
        w_pc_write = 1'b1;
      end
    end

    if (rst) begin
      w_next       = RUN;
      w_drain_nxt  = '0;
      w_br_flush   = 1'b0;
      w_pc_write   = 1'b0;
      w_ifid_stall = 1'b0;
      w_ifid_flush = 1'b1;
      w_idex_flush = 1'b1;
      w_be_freeze  = 1'b0;
      w_halted     = 1'b0;
    end
  end

  assign hif.pc_write   = w_pc_write;
  assign hif.ifid_stall = w_ifid_stall;
  assign hif.ifid_flush = w_ifid_flush;
  assign hif.idex_flush = w_idex_flush;
  assign hif.be_freeze  = w_be_freeze;
  assign hif.halted     = w_halted;

`ifdef HAZ_PERF_EN
  logic [15:0] r_stall_cnt;
  logic [15:0] r_flush_cnt;
  logic        w_stall_evt;

  assign w_stall_evt = ((r_state == RUN) || (r_state == MEM_WAIT)) && !w_pc_write;

  // Saturating counts of PC-stall cycles and branch-caused flushes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall_evt && (r_stall_cnt != 16'hFFFF)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
      if (w_br_flush && (r_flush_cnt != 16'hFFFF)) begin
        r_flush_cnt <= r_flush_cnt + 16'd1;
      end
    end
  end

  assign hif.stall_cnt = r_stall_cnt;
  assign hif.flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl. Control outputs are compared as a
// 6-bit vector {pc_write, ifid_stall, ifid_flush, idex_flush, be_freeze, halted}.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_total = 0;
  int   n_bad   = 0;

  hazard_ctrl_if hif ();

  hazard_ctrl dut (
    .clk (clk),
    .rst (rst),
    .hif (hif)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] outs();
    return {hif.pc_write, hif.ifid_stall, hif.ifid_flush,
            hif.idex_flush, hif.be_freeze, hif.halted};
  endfunction

  task automatic chk(input string tag, input logic [5:0] got, input logic [5:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // let combinational outputs settle after an input change, then compare
  task automatic settle_chk(input string tag, input logic [5:0] exp);
    #1;
    chk(tag, outs(), exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    hif.ifid_inst    = 16'h0000;
    hif.idex_memread = 1'b0;
    hif.idex_rd      = 4'h0;
    hif.br_taken_ex  = 1'b0;
    hif.imem_stall   = 1'b0;
    hif.dmem_stall   = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    settle_chk("rst_hold", 6'b001100);
    step();
    rst = 1'b0;
    settle_chk("rst_release", 6'b100000);
  endtask

  initial begin
    clear_inputs();
    #3;
    chk("reset_vals", outs(), 6'b001100);
    step();
    step();
    rst = 1'b0;
    settle_chk("idle_run", 6'b100000);

    // load-use on rs: one bubble then normal flow
    hif.ifid_inst = 16'h1230; hif.idex_memread = 1'b1; hif.idex_rd = 4'h3;
    settle_chk("lu_rs", 6'b010100);
    step();
    hif.idex_memread = 1'b0;
    settle_chk("lu_after", 6'b100000);

    // r0 exclusion
    hif.ifid_inst = 16'h1200; hif.idex_memread = 1'b1; hif.idex_rd = 4'h0;
    settle_chk("lu_r0", 6'b100000);
    // load-use on rt
    hif.ifid_inst = 16'h1204; hif.idex_rd = 4'h4;
    settle_chk("lu_rt", 6'b010100);
    hif.idex_memread = 1'b0;
    settle_chk("no_load", 6'b100000);
    step();

    // branch beats load-use
    hif.ifid_inst = 16'h1230; hif.idex_memread = 1'b1; hif.idex_rd = 4'h3;
    hif.br_taken_ex = 1'b1;
    settle_chk("br_over_lu", 6'b101100);
    step();
    clear_inputs();

    // imem stall inserts an IF/ID bubble only
    hif.imem_stall = 1'b1;
    settle_chk("imem", 6'b001000);
    step();
    hif.imem_stall = 1'b0;
    settle_chk("imem_off", 6'b100000);

    // dmem stall 4 cycles with pending branch; flushes on release
    hif.dmem_stall = 1'b1; hif.br_taken_ex = 1'b1;
    settle_chk("dmem_c1", 6'b010010);
    for (int i = 0; i < 3; i++) begin
      step();
      settle_chk("dmem_wait", 6'b010010);
    end
    step();
    hif.dmem_stall = 1'b0;
    settle_chk("dmem_release", 6'b101100);
    step();
    hif.br_taken_ex = 1'b0;
    settle_chk("dmem_back_run", 6'b100000);

    // HALT: three drain cycles, then sticky halted
    hif.ifid_inst = 16'hF000;
    settle_chk("halt_seen", 6'b001000);
    step();
    hif.ifid_inst = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      settle_chk("drain", 6'b001000);
      step();
    end
    settle_chk("halted_1", 6'b001101);
    for (int i = 0; i < 100; i++) begin
      step();
      chk("halted_hold", outs(), 6'b001101);
    end
    do_reset();

    // dmem stall during DRAIN freezes and holds the drain count
    hif.ifid_inst = 16'hF000;
    settle_chk("halt2_seen", 6'b001000);
    step();
    hif.ifid_inst = 16'h0000;
    hif.dmem_stall = 1'b1;
    settle_chk("drain_frz", 6'b001010);
    step();
    settle_chk("drain_frz2", 6'b001010);
    step();
    hif.dmem_stall = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle_chk("drain2", 6'b001000);
      step();
    end
    settle_chk("halted_2", 6'b001101);
    do_reset();

    // branch in DRAIN returns to RUN
    hif.ifid_inst = 16'hF000;
    settle_chk("halt3_seen", 6'b001000);
    step();
    hif.ifid_inst = 16'h0000;
    hif.br_taken_ex = 1'b1;
    settle_chk("drain_br", 6'b101100);
    step();
    hif.br_taken_ex = 1'b0;
    settle_chk("drain_br_run", 6'b100000);

    // async reset mid-DRAIN, off the clock edge
    hif.ifid_inst = 16'hF000;
    settle_chk("halt4_seen", 6'b001000);
    step();
    hif.ifid_inst = 16'h0000;
    step();
    #2;
    rst = 1'b1;
    settle_chk("async_rst", 6'b001100);
    step();
    rst = 1'b0;
    settle_chk("after_async", 6'b100000);
    step();
    settle_chk("run_steady", 6'b100000);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
